// File: rtl/cnt8_ns_fsm_pkg.sv
// Shared constants for the cnt8 next-state FSM and the counter output logic.
// Holds the state codes and the cla8 operand constants for +1 / -1.
package cnt8_ns_fsm_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned DATA_W  = 8;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'b000;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'b001;
  localparam logic [STATE_W-1:0] ST_INC  = 3'b010;
  localparam logic [STATE_W-1:0] ST_INC2 = 3'b011;
  localparam logic [STATE_W-1:0] ST_DEC  = 3'b100;
  localparam logic [STATE_W-1:0] ST_DEC2 = 3'b101;

  // a + 0x00 + 1 = a + 1 ; a + 0xFE + 1 = a - 1 (mod 256)
  localparam logic [DATA_W-1:0] CLA_B_INC = 8'h00;
  localparam logic [DATA_W-1:0] CLA_B_DEC = 8'hFE;
  localparam logic              CLA_CI    = 1'b1;

endpackage

// File: rtl/cla8.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups.
module cla8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_ci,
  output logic [7:0] o_s,
  output logic       o_co
);

  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;
  logic       w_gg0;
  logic       w_gp0;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Group 0 carries, fully expanded from i_ci
  assign w_c[0] = i_ci;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign w_gg0 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign w_gp0 = &w_p[3:0];
  assign w_c[4] = w_gg0 | (w_gp0 & w_c[0]);

  // Group 1 carries, expanded from the group-0 lookahead carry
  assign w_c[5] = w_g[4] | (w_p[4] & w_c[4]);
  assign w_c[6] = w_g[5] | (w_p[5] & w_g[4]) | (w_p[5] & w_p[4] & w_c[4]);
  assign w_c[7] = w_g[6] | (w_p[6] & w_g[5]) | (w_p[6] & w_p[5] & w_g[4])
                | (w_p[6] & w_p[5] & w_p[4] & w_c[4]);
  assign w_c[8] = w_g[7] | (w_p[7] & w_g[6]) | (w_p[7] & w_p[6] & w_g[5])
                | (w_p[7] & w_p[6] & w_p[5] & w_g[4])
                | (w_p[7] & w_p[6] & w_p[5] & w_p[4] & w_c[4]);

  assign o_s  = w_p ^ w_c[7:0];
  assign o_co = w_c[8];

endmodule

// File: rtl/cnt8_ns_fsm.sv
// Next-state FSM for the 8-bit counter: picks load/inc/dec/idle each cycle
// and keeps a registered shadow of the counter value with wrap/err pulses.
module cnt8_ns_fsm
  import cnt8_ns_fsm_pkg::*;
#(
  parameter logic [STATE_W-1:0] IDLE_STATE = ST_IDLE,
  parameter logic [STATE_W-1:0] LOAD_STATE = ST_LOAD,
  parameter logic [STATE_W-1:0] INC_STATE  = ST_INC,
  parameter logic [STATE_W-1:0] INC2_STATE = ST_INC2,
  parameter logic [STATE_W-1:0] DEC_STATE  = ST_DEC,
  parameter logic [STATE_W-1:0] DEC2_STATE = ST_DEC2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic              dec,
  input  logic [DATA_W-1:0] d_in,
  output logic [STATE_W-1:0] state,
  output logic [DATA_W-1:0] d_trk,
  output logic              wrap,
  output logic              err
);

  logic [STATE_W-1:0] r_state;
  logic [DATA_W-1:0]  r_d_trk;
  logic               r_wrap;
  logic               r_err;

  logic [STATE_W-1:0] w_nxt_state;
  logic [DATA_W-1:0]  w_nxt_d_trk;
  logic               w_nxt_wrap;
  logic               w_nxt_err;

  logic               w_legal;
  logic               w_inc_only;
  logic               w_dec_only;
  logic [DATA_W-1:0]  w_cla_b;
  logic [DATA_W-1:0]  w_cla_s;
  logic               w_cla_co;

  assign w_legal = (r_state == IDLE_STATE) || (r_state == LOAD_STATE) ||
                   (r_state == INC_STATE)  || (r_state == INC2_STATE) ||
                   (r_state == DEC_STATE)  || (r_state == DEC2_STATE);

  assign w_inc_only = inc & ~dec;
  assign w_dec_only = dec & ~inc;

  // Operand select kept outside the next-state block to avoid a comb loop
  assign w_cla_b = w_dec_only ? CLA_B_DEC : CLA_B_INC;

  cla8 u_cla8 (
    .i_a  (r_d_trk),
    .i_b  (w_cla_b),
    .i_ci (CLA_CI),
    .o_s  (w_cla_s),
    .o_co (w_cla_co)
  );

  // Next state and next registered outputs
  always_comb begin
    w_nxt_state = IDLE_STATE;
    w_nxt_d_trk = 8'h00;
    w_nxt_wrap  = 1'b0;
    w_nxt_err   = 1'b0;

    if (!w_legal) begin
      w_nxt_err = 1'b1;
    end else if (load) begin
      w_nxt_state = LOAD_STATE;
      w_nxt_d_trk = d_in;
    end else if (w_inc_only) begin
      w_nxt_state = (r_state == INC_STATE) ? INC2_STATE : INC_STATE;
      w_nxt_d_trk = w_cla_s;
      w_nxt_wrap  = w_cla_co;
    end else if (w_dec_only) begin
      w_nxt_state = (r_state == DEC_STATE) ? DEC2_STATE : DEC_STATE;
      w_nxt_d_trk = w_cla_s;
      // a + 0xFF carries out for every a except 0x00, which borrows to 0xFF
      w_nxt_wrap  = ~w_cla_co;
    end else if (inc & dec) begin
      w_nxt_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE_STATE;
      r_d_trk <= 8'h00;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_d_trk <= w_nxt_d_trk;
      r_wrap  <= w_nxt_wrap;
      r_err   <= w_nxt_err;
    end
  end

  assign state = r_state;
  assign d_trk = r_d_trk;
  assign wrap  = r_wrap;
  assign err   = r_err;

endmodule

// File: tb/tb_cnt8_ns_fsm.sv
// Directed vector bench for cnt8_ns_fsm: table of per-cycle commands with
// hand-computed outputs, plus an illegal-state recovery sequence.
module tb_cnt8_ns_fsm;

  typedef struct {
    logic       rst;
    logic       load;
    logic       inc;
    logic       dec;
    logic [7:0] d_in;
    logic [2:0] st;
    logic [7:0] trk;
    logic       wrp;
    logic       er;
  } vec_t;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_LOAD = 3'b001;
  localparam logic [2:0] S_INC  = 3'b010;
  localparam logic [2:0] S_INC2 = 3'b011;
  localparam logic [2:0] S_DEC  = 3'b100;
  localparam logic [2:0] S_DEC2 = 3'b101;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       inc;
  logic       dec;
  logic [7:0] d_in;
  logic [2:0] state;
  logic [7:0] d_trk;
  logic       wrap;
  logic       err;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  cnt8_ns_fsm dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .inc   (inc),
    .dec   (dec),
    .d_in  (d_in),
    .state (state),
    .d_trk (d_trk),
    .wrap  (wrap),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic l, input logic i, input logic d,
                     input logic [7:0] din, input logic [2:0] s,
                     input logic [7:0] t, input logic w, input logic e);
    vec_t v;
    v.rst = r; v.load = l; v.inc = i; v.dec = d; v.d_in = din;
    v.st = s; v.trk = t; v.wrp = w; v.er = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic l, input logic i, input logic d,
                       input logic [7:0] din);
    @(negedge clk);
    rst = r; load = l; inc = i; dec = d; d_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; inc = 1'b0; dec = 1'b0; d_in = 8'h00;

    //   rst  ld   inc  dec  d_in   state   d_trk  wrap err
    add(1'b1,1'b0,1'b0,1'b0,8'h00, S_IDLE, 8'h00,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,8'h5A, S_LOAD, 8'h5A,1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,8'h00, S_IDLE, 8'h00,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,8'hFD, S_LOAD, 8'hFD,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,1'b0,8'h00, S_INC,  8'hFE,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,1'b0,8'h00, S_INC2, 8'hFF,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,1'b0,8'h00, S_INC,  8'h00,1'b1,1'b0);
    add(1'b0,1'b0,1'b1,1'b0,8'h00, S_INC2, 8'h01,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,1'b1,8'h00, S_IDLE, 8'h00,1'b0,1'b1);
    add(1'b0,1'b1,1'b1,1'b1,8'h33, S_LOAD, 8'h33,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,8'h01, S_LOAD, 8'h01,1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b1,8'h00, S_DEC,  8'h00,1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b1,8'h00, S_DEC2, 8'hFF,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,1'b1,8'h00, S_DEC,  8'hFE,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,8'h00, S_LOAD, 8'h00,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,8'hFF, S_LOAD, 8'hFF,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,1'b0,8'h00, S_INC,  8'h00,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,1'b1,8'h00, S_DEC,  8'hFF,1'b1,1'b0);
    add(1'b0,1'b0,1'b0,1'b1,8'h00, S_DEC2, 8'hFE,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,1'b0,8'h00, S_INC,  8'hFF,1'b0,1'b0);
    add(1'b0,1'b1,1'b0,1'b0,8'h02, S_LOAD, 8'h02,1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b1,8'h00, S_DEC,  8'h01,1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b1,8'h00, S_DEC2, 8'h00,1'b0,1'b0);
    add(1'b1,1'b0,1'b0,1'b1,8'h00, S_IDLE, 8'h00,1'b0,1'b0);
    add(1'b1,1'b1,1'b1,1'b1,8'hAA, S_IDLE, 8'h00,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,1'b0,8'h00, S_INC,  8'h01,1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,8'h00, S_IDLE, 8'h00,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,1'b0,8'h00, S_INC,  8'h01,1'b0,1'b0);
    add(1'b0,1'b0,1'b1,1'b0,8'h00, S_INC2, 8'h02,1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b1,8'h00, S_DEC,  8'h01,1'b0,1'b0);
    add(1'b0,1'b0,1'b0,1'b0,8'h00, S_IDLE, 8'h00,1'b0,1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].load, vecs[i].inc, vecs[i].dec, vecs[i].d_in);
      chk("state", i, 8'(state), 8'(vecs[i].st));
      chk("d_trk", i, d_trk, vecs[i].trk);
      chk("wrap",  i, 8'(wrap),  8'(vecs[i].wrp));
      chk("err",   i, 8'(err),   8'(vecs[i].er));
    end

    // Unused state code recovers to IDLE with a single err pulse
    @(negedge clk);
    rst = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0; d_in = 8'h00;
    force dut.r_state = 3'b111;
    #1;
    release dut.r_state;
    #1;
    chk("forced_state", 100, 8'(state), 8'h07);
    @(posedge clk);
    #1;
    chk("illegal_state", 101, 8'(state), 8'(S_IDLE));
    chk("illegal_err",   101, 8'(err), 8'h01);
    chk("illegal_trk",   101, d_trk, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("illegal_err_clr", 102, 8'(err), 8'h00);
    chk("illegal_state2",  102, 8'(state), 8'(S_IDLE));

    // Sustained increment: state code must differ on every cycle
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] prev;
      prev = state;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("inc_toggle", 200 + k, 8'(state != prev), 8'h01);
      chk("inc_value",  200 + k, d_trk, 8'(8'h11 + k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
